lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter N, default 32, data width of DIN; the function is defined for N=32 only.
REQ-002 Parameter LOCK_CNT, default 4, consecutive matches after the seed sample required to lock (1..15).
REQ-003 Parameter LOSS_CNT, default 3, consecutive mismatches while locked that drop lock (1..15).
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 VALID  input  1  DIN carries a new generator sample this cycle (driven by the generator's GO).
REQ-007 DIN  input  N  sample from the upstream 32-bit LFSR Q output.
REQ-008 CLR  input  1  synchronous clear of ERR_CNT.
REQ-009 LOCKED  output  1  checker is synchronised to the sequence.
REQ-010 ERR  output  1  one-cycle pulse per mismatch while locked.
REQ-011 ERR_CNT  output  16  saturating mismatch count.
REQ-012 ZERO  output  1  all-zero lock-up sample seen (see Configuration).

Function
REQ-013 The reference step SHALL be next(x) = {fb, x[31:1]}, with fb = x[31]^x[21]^x[1]^x[0]; for example, next(0x12345678) = 0x891A2B3C.
REQ-014 All outputs SHALL be registered; the response to a VALID sample SHALL appear in the cycle after the sampling edge.
REQ-015 With VALID low, all state SHALL hold and ERR SHALL be 0.
REQ-016 Internal state: FSM {IDLE, ACQ, LOCK}, ref[N-1:0], match_cnt[3:0], miss_cnt[3:0].
REQ-017 IDLE + VALID: ref <= next(DIN), match_cnt <= 0, go to ACQ.
REQ-018 ACQ + VALID and DIN==ref: ref <= next(DIN), match_cnt++; when match_cnt+1==LOCK_CNT, go to LOCK, set LOCKED=1, and clear miss_cnt.
REQ-019 ACQ + VALID and DIN!=ref: re-seed (ref <= next(DIN)), match_cnt <= 0, stay in ACQ; ERR and ERR_CNT are unaffected.
REQ-020 LOCK + VALID: ref <= next(ref) (flywheel; never re-seeded from DIN while locked).
REQ-021 LOCK + VALID and DIN==ref: miss_cnt <= 0.
REQ-022 LOCK + VALID and DIN!=ref: ERR=1 for one cycle, ERR_CNT++ saturating at 0xFFFF, miss_cnt++.
REQ-023 On the LOCK mismatch where miss_cnt+1==LOSS_CNT: go to ACQ, set LOCKED=0, ref <= next(DIN), match_cnt <= 0.
REQ-024 CLR alone: ERR_CNT <= 0.
REQ-025 CLR in the same cycle as a counted mismatch: ERR_CNT <= 1.
REQ-026 Saturation: while ERR_CNT==0xFFFF, further mismatches still pulse ERR but ERR_CNT holds.

Reset
REQ-027 RST at any time, including mid-acquisition, SHALL force IDLE with ref, match_cnt, miss_cnt, LOCKED, ERR, ERR_CNT and ZERO all 0 on the next edge.
REQ-028 RST SHALL dominate VALID and CLR in the same cycle.

Configuration
REQ-029 Macro LFSR_CHECKER_ZERO_DET_EN defined: VALID with DIN==0 sets sticky ZERO=1 (cleared only by RST), and the sample is treated as a mismatch in every state.
REQ-030 Macro undefined: ZERO is tied to 0, no zero-detection logic is present, and DIN==0 is handled only by REQ-017..REQ-023.

Verification
REQ-031 RST, then VALID with the correct sequence 0x12345678, 0x891A2B3C, ... (5 samples) -> LOCKED=1 one cycle after the 5th sample; ERR never pulses; ERR_CNT=0.
REQ-032 Locked, one sample with bit0 flipped, then correct samples -> single ERR pulse, ERR_CNT=1, LOCKED stays 1, and following correct samples cause no ERR.
REQ-033 Locked, 3 consecutive wrong samples -> 3 ERR pulses, ERR_CNT=3, LOCKED=0 after the 3rd; 4 further correct samples relock (LOCKED=1).
REQ-034 Locked, VALID low for 10 cycles, then the correct next sample -> no state change and no ERR.
REQ-035 ERR_CNT=5, CLR asserted with a locked mismatch -> ERR_CNT=1; then RST while in ACQ -> all outputs 0 and state IDLE.
REQ-036 Macro defined, VALID with DIN=0x00000000 -> ZERO=1 and held until RST; macro undefined -> ZERO=0.

Source files
------------

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Follows the output of an upstream 32-bit Fibonacci LFSR and reports whether
// the received samples track the expected sequence.
//
// The checker seeds itself from the first sample. It then acquires lock after
// LOCK_CNT consecutive correctly predicted samples. While locked it free-runs
// its own reference ("flywheel"), so corrupted samples are counted rather than
// re-seeded. Lock is dropped after LOSS_CNT consecutive mismatches.
//
// Polynomial step: next(x) = {x[31]^x[21]^x[1]^x[0], x[31:1]}
//
// Parameters
//   N         data width of din (the step function is defined for 32 only)
//   LOCK_CNT  consecutive matches after the seed sample needed to lock (1..15)
//   LOSS_CNT  consecutive mismatches while locked that drop lock   (1..15)
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset, dominates valid and clr
//   valid    in   din carries a new generator sample this cycle
//   din      in   N-bit sample from the generator
//   clr      in   synchronous clear of err_cnt
//   locked   out  checker is synchronised to the sequence
//   err      out  one-cycle pulse per mismatch while locked
//   err_cnt  out  16-bit saturating mismatch count
//   zero     out  sticky flag: an all-zero (lock-up) sample was seen
//
// Optional feature
//   LFSR_CHECKER_ZERO_DET_EN  when defined, a valid all-zero sample sets the
//   sticky zero flag (cleared only by rst) and is treated as a mismatch in
//   every state; in IDLE it is not used as a seed. When undefined, zero is
//   tied low and an all-zero sample is handled like any other value.
//
// All outputs come straight from registers: the response to a sample taken
// on edge k is visible after edge k.
// -----------------------------------------------------------------------------
module lfsr_checker #(
    parameter int N        = 32,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [N-1:0] din,
    input  logic         clr,
    output logic         locked,
    output logic         err,
    output logic [15:0]  err_cnt,
    output logic         zero
);

    // Thresholds narrowed to the width of the run counters.
    localparam logic [3:0] LOCK_CNT_C = LOCK_CNT[3:0];
    localparam logic [3:0] LOSS_CNT_C = LOSS_CNT[3:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  ref_reg, ref_next;
    logic [3:0]    match_cnt_reg, match_cnt_next;
    logic [3:0]    miss_cnt_reg, miss_cnt_next;
    logic          err_reg, err_next;
    logic [15:0]   err_cnt_reg, err_cnt_next;
    logic          count_err;

    // -------------------------------------------------------------------------
    // LFSR step of the incoming sample (used for seeding) and of the current
    // reference (used by the flywheel while locked). The shift part is pure
    // wiring; only the MSB carries the feedback XOR.
    // -------------------------------------------------------------------------
    logic [N-1:0] din_step;
    logic [N-1:0] ref_step;

    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_shift
            assign din_step[gi] = din[gi+1];
            assign ref_step[gi] = ref_reg[gi+1];
        end
    endgenerate

    assign din_step[N-1] = din[N-1] ^ din[21] ^ din[1] ^ din[0];
    assign ref_step[N-1] = ref_reg[N-1] ^ ref_reg[21] ^ ref_reg[1] ^ ref_reg[0];

    // -------------------------------------------------------------------------
    // Sample classification
    //   zero_hit  : valid all-zero sample that the optional detector flags
    //   sample_ok : sample equals the predicted value and is not flagged
    // -------------------------------------------------------------------------
    logic zero_hit;
    logic sample_ok;

`ifdef LFSR_CHECKER_ZERO_DET_EN
    logic zero_reg;

    assign zero_hit  = (din == '0);
    assign sample_ok = (din == ref_reg) && !zero_hit;

    // Sticky: once a lock-up sample has been seen, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_reg <= 1'b0;
        end else if (valid && zero_hit) begin
            zero_reg <= 1'b1;
        end
    end

    assign zero = zero_reg;
`else
    assign zero_hit  = 1'b0;
    assign sample_ok = (din == ref_reg);
    assign zero      = 1'b0;
`endif

    // Run-length thresholds reached on this sample.
    logic acq_done;
    logic loss_done;

    assign acq_done  = ((match_cnt_reg + 4'd1) == LOCK_CNT_C);
    assign loss_done = ((miss_cnt_reg + 4'd1) == LOSS_CNT_C);

    // -------------------------------------------------------------------------
    // Process 1: state and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ref_reg       <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ref_reg       <= ref_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (valid) begin
            case (state_reg)
                IDLE: begin
                    // A flagged zero sample is never used as a seed.
                    if (!zero_hit) begin
                        state_next = ACQ;
                    end
                end
                ACQ: begin
                    if (sample_ok && acq_done) begin
                        state_next = LOCK;
                    end
                end
                LOCK: begin
                    if (!sample_ok && loss_done) begin
                        state_next = ACQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next values (reference, run counters, error counter)
    // -------------------------------------------------------------------------
    always_comb begin
        ref_next       = ref_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_next       = 1'b0;
        count_err      = 1'b0;

        if (valid) begin
            case (state_reg)
                IDLE: begin
                    if (!zero_hit) begin
                        ref_next       = din_step;
                        match_cnt_next = 4'd0;
                    end
                end
                ACQ: begin
                    // Whether it matched or not, the next prediction follows
                    // the sample just received; a miss only restarts the run.
                    ref_next = din_step;
                    if (sample_ok) begin
                        match_cnt_next = match_cnt_reg + 4'd1;
                        if (acq_done) begin
                            miss_cnt_next = 4'd0;
                        end
                    end else begin
                        match_cnt_next = 4'd0;
                    end
                end
                LOCK: begin
                    // Flywheel: the reference advances on its own so a single
                    // corrupted sample cannot pull the checker off-sequence.
                    ref_next = ref_step;
                    if (sample_ok) begin
                        miss_cnt_next = 4'd0;
                    end else begin
                        err_next      = 1'b1;
                        count_err     = 1'b1;
                        miss_cnt_next = miss_cnt_reg + 4'd1;
                        if (loss_done) begin
                            // Falling back to acquisition: re-seed from the
                            // sample actually received.
                            ref_next       = din_step;
                            match_cnt_next = 4'd0;
                        end
                    end
                end
                default: begin
                    ref_next       = '0;
                    match_cnt_next = 4'd0;
                    miss_cnt_next  = 4'd0;
                end
            endcase
        end

        // Clear wins over increment, but a mismatch in the clearing cycle is
        // still counted so it is not lost.
        err_cnt_next = err_cnt_reg;
        if (clr) begin
            err_cnt_next = {15'd0, count_err};
        end else if (count_err && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_next = err_cnt_reg + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: outputs (all sourced from registers)
    // -------------------------------------------------------------------------
    always_comb begin
        locked  = (state_reg == LOCK);
        err     = err_reg;
        err_cnt = err_cnt_reg;
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//
// Scoreboard bench for lfsr_checker. The driver issues one transaction per
// clock and, at the sampling edge, runs a behavioural model of the checker
// and queues the expected outputs. A separate monitor pops one entry after
// every edge and compares it with the DUT outputs.
//
// The stimulus starts with directed sequences (acquire, single error, VALID
// gaps, loss and relock, clear with mismatch, reset in acquisition, all-zero
// sample). It then runs a long randomized stream from a software generator
// with injected bit errors, VALID gaps, clears and resets.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

`ifdef LFSR_CHECKER_ZERO_DET_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] din = '0;
    logic        clr = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic        zero;

    always #5 clk = ~clk;

    lfsr_checker #(
        .N        (32),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .din     (din),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt),
        .zero    (zero)
    );

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [31:0] din;
        logic        clr;
        logic        locked;
        logic        err;
        logic [15:0] err_cnt;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // ---------------- behavioural reference model ----------------
    bit          m_seeded;
    bit          m_synced;
    bit          m_zero;
    bit          m_err;
    logic [31:0] m_expect;
    int          m_runs;
    int          m_misses;
    int          m_errs;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[31] ^ x[21] ^ x[1] ^ x[0], x[31:1]};
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [31:0] d,
                              input logic c);
        bit   bad;
        bit   counted;
        bit   z;
        exp_t e;
        counted = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_seeded = 0; m_synced = 0; m_zero = 0;
            m_expect = '0; m_runs = 0; m_misses = 0; m_errs = 0;
        end else begin
            if (v) begin
                z   = ZERO_EN && (d == 32'd0);
                bad = (d != m_expect) || z;
                if (z) m_zero = 1'b1;
                if (!m_seeded) begin
                    if (!z) begin
                        m_seeded = 1'b1;
                        m_expect = lfsr_step(d);
                        m_runs   = 0;
                    end
                end else if (!m_synced) begin
                    m_expect = lfsr_step(d);
                    if (bad) begin
                        m_runs = 0;
                    end else begin
                        m_runs++;
                        if (m_runs == LOCK_CNT) begin
                            m_synced = 1'b1;
                            m_misses = 0;
                        end
                    end
                end else begin
                    if (!bad) begin
                        m_misses = 0;
                        m_expect = lfsr_step(m_expect);
                    end else begin
                        m_err   = 1'b1;
                        counted = 1'b1;
                        m_misses++;
                        if (m_misses == LOSS_CNT) begin
                            m_synced = 1'b0;
                            m_runs   = 0;
                            m_expect = lfsr_step(d);
                        end else begin
                            m_expect = lfsr_step(m_expect);
                        end
                    end
                end
            end
            if (c) m_errs = counted ? 1 : 0;
            else if (counted && m_errs < 65535) m_errs++;
        end
        e.rst     = r;
        e.valid   = v;
        e.din     = d;
        e.clr     = c;
        e.locked  = m_synced;
        e.err     = m_err;
        e.err_cnt = 16'(m_errs);
        e.zero    = m_zero;
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    logic [31:0] gen;

    task automatic drive(input logic r, input logic v, input logic [31:0] d,
                         input logic c);
        @(negedge clk);
        rst   = r;
        valid = v;
        din   = d;
        clr   = c;
        @(posedge clk);
        model_step(r, v, d, c);
    endtask

    task automatic send_good();
        drive(1'b0, 1'b1, gen, 1'b0);
        gen = lfsr_step(gen);
    endtask

    task automatic send_bad(input int bitpos, input logic c);
        logic [31:0] flip;
        flip = 32'd1 << bitpos;
        drive(1'b0, 1'b1, gen ^ flip, c);
        gen = lfsr_step(gen);
    endtask

    task automatic idle(input int n, input logic c);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, c);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("t=%0t rst=%b valid=%b din=%h clr=%b | locked=%b err=%b err_cnt=%0d zero=%b",
                         $time, e.rst, e.valid, e.din, e.clr, locked, err, err_cnt, zero);
                cmp("locked",  {15'd0, locked}, {15'd0, e.locked});
                cmp("err",     {15'd0, err},    {15'd0, e.err});
                cmp("err_cnt", err_cnt,         e.err_cnt);
                cmp("zero",    {15'd0, zero},   {15'd0, e.zero});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        logic r, v, c;

        // Reset state
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);

        // Acquire on the reference sequence
        gen = 32'h12345678;
        for (int i = 0; i < 5; i++) send_good();
        idle(2, 1'b0);

        // Single corrupted sample while locked
        send_bad(0, 1'b0);
        for (int i = 0; i < 3; i++) send_good();

        // VALID gap, then the correct next sample
        idle(10, 1'b0);
        send_good();

        // Loss of lock and re-acquisition
        for (int i = 0; i < 3; i++) send_bad(i + 4, 1'b0);
        for (int i = 0; i < 8; i++) send_good();

        // Bring the count to five, then clear in a mismatch cycle
        send_bad(7, 1'b0);
        send_good();
        send_good();
        send_bad(9, 1'b1);
        send_good();

        // Clear alone
        idle(1, 1'b1);

        // Drop to acquisition, reset mid-acquisition
        for (int i = 0; i < 3; i++) send_bad(31, 1'b0);
        send_good();
        send_good();
        drive(1'b1, 1'b1, gen, 1'b0);
        idle(2, 1'b0);

        // All-zero sample from IDLE and from ACQ
        drive(1'b0, 1'b1, 32'd0, 1'b0);
        drive(1'b0, 1'b1, 32'd0, 1'b0);
        idle(2, 1'b0);
        gen = 32'hCAFEF00D;
        for (int i = 0; i < 6; i++) send_good();
        drive(1'b0, 1'b1, 32'd0, 1'b0);
        gen = lfsr_step(gen);
        for (int i = 0; i < 3; i++) send_good();

        // Randomized stream
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 299) == 0);
            v    = ($urandom_range(0, 3) != 0);
            c    = ($urandom_range(0, 49) == 0);
            kind = $urandom_range(0, 39);
            if (r) begin
                drive(1'b1, v, gen, c);
                gen = $urandom | 32'd1;
            end else if (!v) begin
                drive(1'b0, 1'b0, $urandom, c);
            end else if (kind < 3) begin
                send_bad($urandom_range(0, 31), c);
            end else if (kind == 3) begin
                drive(1'b0, 1'b1, 32'd0, c);
                gen = lfsr_step(gen);
            end else begin
                drive(1'b0, 1'b1, gen, c);
                gen = lfsr_step(gen);
            end
        end
        idle(2, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
